// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the multiply/divide unit and its neighbours.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    // Edges from accepting start to the edge that writes HI/LO.
    localparam int MD_LATENCY = 33;

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_shift_core.sv
// Shift-register datapath shared by multiply and divide: one shift-add
// (multiply) or shift-subtract-restore (divide) step per enabled edge.
// Operates on magnitudes only; sign handling lives in the parent.
module md_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] opnd;
    logic             mode;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl_rem;
    logic [WIDTH:0]   trial;

    // Candidate next values for both step kinds. Since the partial remainder
    // is always below the divisor, shl_rem < 2*divisor, so bit WIDTH of the
    // 33-bit trial difference is exactly the borrow.
    always_comb begin
        add_sum = {1'b0, acc} + (q[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shl_rem = {acc, q[WIDTH-1]};
        trial   = shl_rem - {1'b0, opnd};
    end

    // Load operands, then advance one iteration per step.
    always_ff @(posedge clk) begin
        if (load) begin
            acc  <= '0;
            q    <= div_mode ? a_mag : b_mag;
            opnd <= div_mode ? b_mag : a_mag;
            mode <= div_mode;
        end else if (step) begin
            if (mode) begin
                if (!trial[WIDTH]) begin
                    acc <= trial[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= shl_rem[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc <= add_sum[WIDTH:1];
                q   <= {add_sum[0], q[WIDTH-1:1]};
            end
        end
    end

    assign acc_out = acc;
    assign q_out   = q;

endmodule

// File: rtl/mul_div_unit.sv
// MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting; start accepted, MTHI/MTLO honoured when no start
//  ST_RUN  | one core iteration per edge, ITER edges total
//  ST_FIX  | apply sign correction, write HI/LO, pulse done
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(ITER);

    md_state_e        state_q;
    md_state_e        state_d;
    logic             load_go;
    logic             step_go;
    logic             fix_go;
    logic             idle_write;
    logic [CNT_W-1:0] count_q;

    logic             neg_a_q;
    logic             neg_b_q;
    logic             div_q;
    logic             zero_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d    = state_q;
        load_go    = 1'b0;
        step_go    = 1'b0;
        fix_go     = 1'b0;
        idle_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_go = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    idle_write = 1'b1;
                end
            end
            ST_RUN: begin
                step_go = 1'b1;
                if (count_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                fix_go  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand magnitudes; 0x80000000 negates to itself, which is the right
    // unsigned magnitude for the core.
    always_comb begin
        a_neg = is_signed_op(md_op) & a_in[WIDTH-1];
        b_neg = is_signed_op(md_op) & b_in[WIDTH-1];
        a_mag = a_neg ? -a_in : a_in;
        b_mag = b_neg ? -b_in : b_in;
    end

    md_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .load     (load_go),
        .step     (step_go),
        .div_mode (is_div_op(md_op)),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_out  (core_hi),
        .q_out    (core_lo)
    );

    // Sign correction of the finished magnitudes. On divide-by-zero the core's
    // accumulator has shifted in every dividend bit, so it holds |a|; restoring
    // the dividend sign gives back a_in for HI.
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -{core_hi, core_lo} : {core_hi, core_lo};
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (div_q) begin
            fix_hi = neg_a_q ? -core_hi : core_hi;
            if (zero_q)                 fix_lo = '1;
            else if (neg_a_q ^ neg_b_q) fix_lo = -core_lo;
            else                        fix_lo = core_lo;
        end
    end

    // Iteration counter and operation flags latched at start.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (load_go) begin
            count_q <= '0;
            neg_a_q <= a_neg;
            neg_b_q <= b_neg;
            div_q   <= is_div_op(md_op);
            zero_q  <= (b_in == '0);
        end else if (step_go) begin
            count_q <= count_q + 1'b1;
        end
    end

    // HI/LO: result write at FIX, otherwise MTHI/MTLO while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_out <= '0;
            lo_out <= '0;
        end else if (fix_go) begin
            hi_out <= fix_hi;
            lo_out <= fix_lo;
        end else if (idle_write) begin
            if (mthi) hi_out <= a_in;
            if (mtlo) lo_out <= a_in;
        end
    end

    // Done pulse coincides with the HI/LO update.
    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else     done <= fix_go;
    end

    assign busy = (state_q != ST_IDLE);

endmodule
